rv_buf_n: RTL

- Parametrised valid/ready elastic buffer that replaces single-entry pipe/skid slices on long datapaths.
- Holds up to DEPTH words and sustains one transfer per cycle under arbitrary backpressure.
- All handshake outputs are driven only from flops, so no combinational path exists from dataout_rdy to datain_rdy, or from datain_val to dataout_val.
- Adds occupancy reporting, an almost-full threshold and a synchronous flush, none of which the single-entry slices provide.

---
 rtl/rv_buf_n.sv | 94 +++++++++
 1 files changed

// File: rtl/rv_buf_n.sv
// rtl/rv_buf_n.sv - valid/ready elastic buffer, DEPTH entries, fully registered handshake
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   flush        synchronous discard of all stored words
//   datain       upstream data (WD bits)
//   datain_val   upstream valid
//   datain_rdy   buffer can accept a word (registered)
//   dataout      head-of-buffer data (registered)
//   dataout_val  head word present (registered)
//   dataout_rdy  downstream ready
//   level        stored word count, 0..DEPTH (registered)
//   almost_full  level >= AF_THRESH (registered)
module rv_buf_n #(
  parameter int WD        = 4,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int LW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [WD-1:0] datain,
  input  logic          datain_val,
  output logic          datain_rdy,
  output logic [WD-1:0] dataout,
  output logic          dataout_val,
  input  logic          dataout_rdy,
  output logic [LW-1:0] level,
  output logic          almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Every accepted word is written at wr_ptr; rd_ptr tracks the slot that
  // currently sits in the dataout register. The memory copy of the head is
  // redundant but keeps pointer arithmetic uniform.
  logic [WD-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_nxt;

  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_comb begin
    push      = datain_val && datain_rdy;
    pop       = dataout_val && dataout_rdy;
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      dataout_val <= 1'b0;
      datain_rdy  <= 1'b1;
      almost_full <= 1'b0;
      dataout     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      level       <= level_nxt;
      // Handshake outputs are computed from next level so they come from flops.
      dataout_val <= (level_nxt != '0);
      datain_rdy  <= (level_nxt != LW'(DEPTH));
      almost_full <= (level_nxt >= LW'(AF_THRESH));
      // Head register: load directly from datain when the incoming word becomes
      // the head (empty, or the only word leaves this cycle); otherwise advance
      // to the next stored word, which exists whenever level >= 2.
      if (push && ((level == '0) || (pop && level == LW'(1)))) begin
        dataout <= datain;
      end else if (pop && (level >= LW'(2))) begin
        dataout <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule
